// File: rtl/fetch_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes and sequencer states.
package fetch_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_OUT    = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/icode_len_decode.sv
// Combinational icode classifier: instruction length and which optional fields follow byte 0.
module icode_len_decode
    import fetch_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       need_regids,
    output logic       need_valc,
    output logic       instr_valid
);

    // Length/field table for the twelve defined instruction codes.
    always_comb begin
        len         = 4'd1;
        need_regids = 1'b0;
        need_valc   = 1'b0;
        instr_valid = 1'b1;
        case (icode)
            IHALT, INOP, IRET: begin
                len = 4'd1;
            end
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                len         = 4'd2;
                need_regids = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                len         = 4'd10;
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            IJXX, ICALL: begin
                len       = 4'd9;
                need_valc = 1'b1;
            end
            default: begin
                len         = 4'd1;
                instr_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Y86-64 fetch controller: reads an instruction byte by byte, assembles its fields and
// hands the record to decode over valid/ready before moving on to the next PC.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int MAX_LEN = 10
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [7:0]        imem_rdata,
    input  logic              imem_err,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [2:0]        stat,
    output logic              busy
);

    localparam int OFF_W = $clog2(MAX_LEN);

    fetch_state_e      state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [OFF_W-1:0]  offset_r, offset_nxt_s;
    logic [3:0]        icode_r, icode_nxt_s, ifun_r, ifun_nxt_s;
    logic [3:0]        ra_r, ra_nxt_s, rb_r, rb_nxt_s;
    logic [63:0]       valc_r, valc_nxt_s;
    logic [ADDR_W-1:0] valp_r, valp_nxt_s;
    logic [2:0]        stat_r, stat_nxt_s;
    logic              imem_req_r, req_nxt_s, out_valid_r, out_valid_nxt_s, busy_r;
    logic [ADDR_W-1:0] imem_addr_r, addr_nxt_s;
    logic              launch_s, first_s, last_s, in_valc_s;
    logic [3:0]        icode_sel_s, len_s, base_s;
    logic [2:0]        k_s;
    logic              need_regids_s, need_valc_s, instr_valid_s;

    // Byte 0 is classified straight off the bus; later bytes use the captured icode.
    assign first_s     = (offset_r == {OFF_W{1'b0}});
    assign icode_sel_s = first_s ? imem_rdata[7:4] : icode_r;

    icode_len_decode u_len_decode (
        .icode       (icode_sel_s),
        .len         (len_s),
        .need_regids (need_regids_s),
        .need_valc   (need_valc_s),
        .instr_valid (instr_valid_s)
    );

    assign last_s    = (4'(offset_r) == (len_s - 4'd1));
    assign base_s    = need_regids_s ? 4'd2 : 4'd1;
    assign k_s       = 3'(4'(offset_r) - base_s);
    assign in_valc_s = need_valc_s && (4'(offset_r) >= base_s);

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        offset_nxt_s    = offset_r;
        icode_nxt_s     = icode_r;
        ifun_nxt_s      = ifun_r;
        ra_nxt_s        = ra_r;
        rb_nxt_s        = rb_r;
        valc_nxt_s      = valc_r;
        valp_nxt_s      = valp_r;
        stat_nxt_s      = stat_r;
        req_nxt_s       = imem_req_r;
        addr_nxt_s      = imem_addr_r;
        out_valid_nxt_s = out_valid_r;
        launch_s        = 1'b0;
        case (state_r)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    launch_s = 1'b1;
                    pc_nxt_s = start_pc;
                end else begin
                    launch_s = 1'b0;
                end
            end
            S_FETCH: begin
                if (imem_req_r && imem_rvalid) begin
                    if (imem_err) begin
                        // A partially assembled constant is meaningless after an address fault.
                        stat_nxt_s      = SADR;
                        valc_nxt_s      = 64'd0;
                        req_nxt_s       = 1'b0;
                        out_valid_nxt_s = 1'b1;
                        state_nxt_s     = S_OUT;
                    end else begin
                        if (first_s) begin
                            icode_nxt_s = imem_rdata[7:4];
                            ifun_nxt_s  = imem_rdata[3:0];
                            valp_nxt_s  = pc_r + ADDR_W'(len_s);
                        end else begin
                            icode_nxt_s = icode_r;
                        end
                        if ((4'(offset_r) == 4'd1) && need_regids_s) begin
                            ra_nxt_s = imem_rdata[7:4];
                            rb_nxt_s = imem_rdata[3:0];
                        end else begin
                            ra_nxt_s = ra_r;
                        end
                        if (in_valc_s) begin
                            valc_nxt_s[{k_s, 3'b000} +: 8] = imem_rdata;
                        end else begin
                            valc_nxt_s = valc_r;
                        end
                        if (!instr_valid_s) begin
                            stat_nxt_s      = SINS;
                            req_nxt_s       = 1'b0;
                            out_valid_nxt_s = 1'b1;
                            state_nxt_s     = S_OUT;
                        end else if (last_s) begin
                            stat_nxt_s      = (icode_sel_s == IHALT) ? SHLT : SAOK;
                            req_nxt_s       = 1'b0;
                            out_valid_nxt_s = 1'b1;
                            state_nxt_s     = S_OUT;
                        end else begin
                            offset_nxt_s = offset_r + OFF_W'(1);
                            addr_nxt_s   = pc_r + ADDR_W'(offset_nxt_s);
                        end
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    if (stat_r == SAOK) begin
                        launch_s = 1'b1;
                        pc_nxt_s = redirect_valid ? redirect_pc : valp_r;
                    end else begin
                        state_nxt_s = S_HALTED;
                    end
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            default: begin
                state_nxt_s     = S_IDLE;
                req_nxt_s       = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
        if (launch_s) begin
            state_nxt_s  = S_FETCH;
            offset_nxt_s = {OFF_W{1'b0}};
            req_nxt_s    = 1'b1;
            addr_nxt_s   = pc_nxt_s;
            icode_nxt_s  = 4'h0;
            ifun_nxt_s   = 4'h0;
            ra_nxt_s     = RNONE;
            rb_nxt_s     = RNONE;
            valc_nxt_s   = 64'd0;
            valp_nxt_s   = {ADDR_W{1'b0}};
            stat_nxt_s   = 3'd0;
        end else begin
            offset_nxt_s = offset_nxt_s;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            pc_r        <= {ADDR_W{1'b0}};
            offset_r    <= {OFF_W{1'b0}};
            icode_r     <= 4'h0;
            ifun_r      <= 4'h0;
            ra_r        <= RNONE;
            rb_r        <= RNONE;
            valc_r      <= 64'd0;
            valp_r      <= {ADDR_W{1'b0}};
            stat_r      <= 3'd0;
            imem_req_r  <= 1'b0;
            imem_addr_r <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            offset_r    <= offset_nxt_s;
            icode_r     <= icode_nxt_s;
            ifun_r      <= ifun_nxt_s;
            ra_r        <= ra_nxt_s;
            rb_r        <= rb_nxt_s;
            valc_r      <= valc_nxt_s;
            valp_r      <= valp_nxt_s;
            stat_r      <= stat_nxt_s;
            imem_req_r  <= req_nxt_s;
            imem_addr_r <= addr_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= (state_nxt_s == S_FETCH) || (state_nxt_s == S_OUT);
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign out_valid = out_valid_r;
    assign icode     = icode_r;
    assign ifun      = ifun_r;
    assign rA        = ra_r;
    assign rB        = rb_r;
    assign valC      = valc_r;
    assign valP      = valp_r;
    assign stat      = stat_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model, scoreboard of expected records, vector table
// plus hand-written sequences for redirect, stalls and mid-fetch reset.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, imem_req, imem_rvalid, imem_err, out_valid, out_ready;
    logic        redirect_valid, busy;
    logic [63:0] start_pc, imem_addr, redirect_pc, valC, valP;
    logic [7:0]  imem_rdata;
    logic [3:0]  icode, ifun, rA, rB;
    logic [2:0]  stat;

    logic [7:0]  mem [0:4095];
    logic        rvalid_en, err_en;
    logic [63:0] err_addr;

    always #5 clk = ~clk;

    assign imem_rdata  = mem[imem_addr[11:0]];
    assign imem_rvalid = rvalid_en;
    assign imem_err    = err_en && (imem_addr == err_addr);

    fetch_sequencer #(.ADDR_W(64), .MAX_LEN(10)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_err(imem_err), .out_valid(out_valid),
        .out_ready(out_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .stat(stat), .busy(busy)
    );

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        logic        chk_valp;
    } rec_t;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          nb;
        int          err_off;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        logic        chk_valp;
        logic        chain;
    } vec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                                input logic [2:0] st, input logic cv);
        rec_t r;
        r.icode = ic; r.ifun = ifn; r.ra = ra; r.rb = rb;
        r.valc = vc; r.valp = vp; r.stat = st; r.chk_valp = cv;
        return r;
    endfunction

    // Scoreboard: every accepted record is compared with the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got icode=%h valP=%h, expected no record", icode, valP);
            end else begin
                mon_r = exp_q.pop_front();
                chk("icode", 64'(icode), 64'(mon_r.icode));
                chk("ifun", 64'(ifun), 64'(mon_r.ifun));
                chk("rA", 64'(rA), 64'(mon_r.ra));
                chk("rB", 64'(rB), 64'(mon_r.rb));
                chk("valC", valC, mon_r.valc);
                chk("stat", 64'(stat), 64'(mon_r.stat));
                if (mon_r.chk_valp) chk("valP", valP, mon_r.valp);
            end
        end
    end

    task automatic load(input logic [63:0] pc, input logic [79:0] b, input int nb);
        for (int k = 0; k < nb; k++) mem[12'(pc + 64'(k))] = b[8*k +: 8];
    endtask

    task automatic kick(input logic [63:0] pc);
        @(negedge clk);
        start_pc = pc;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("valid_in_budget", 64'(n < 200), 64'd1);
    endtask

    task automatic wait_done(output int xf);
        int n;
        n  = 0;
        xf = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            if (imem_req && imem_rvalid) xf++;
            @(negedge clk);
            n++;
        end
        chk("done_in_budget", 64'(n < 300), 64'd1);
    endtask

    initial begin
        int          n, xf;
        logic        prev_pend;
        logic [63:0] prev_addr;
        rec_t        e;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        reset = 1'b1; start = 1'b0; start_pc = 64'd0; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 64'd0; rvalid_en = 1'b1;
        err_en = 1'b0; err_addr = 64'd0;

        vecs[0] = '{64'h400, 80'hC0, 1, -1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, SINS, 1'b0, 1'b0};
        vecs[1] = '{64'h500, 80'h22_11_12_50, 4, 3, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0, 64'h50A, SADR, 1'b1, 1'b0};
        vecs[2] = '{64'h600, 80'hAB_25, 2, -1, 4'h2, 4'h5, 4'hA, 4'hB, 64'h0, 64'h602, SAOK, 1'b1, 1'b1};
        vecs[3] = '{64'h610, 80'h01_23_45_67_89_AB_CD_EF_80, 9, -1, 4'h8, 4'h0, 4'hF, 4'hF,
                    64'h0123_4567_89AB_CDEF, 64'h619, SAOK, 1'b1, 1'b1};
        vecs[4] = '{64'h620, 80'h90, 1, -1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h621, SAOK, 1'b1, 1'b1};
        vecs[5] = '{64'h630, 80'h5F_A0, 2, -1, 4'hA, 4'h0, 4'h5, 4'hF, 64'h0, 64'h632, SAOK, 1'b1, 1'b1};
        vecs[6] = '{64'h640, 80'h88_77_66_55_44_33_22_11_67_40, 10, -1, 4'h4, 4'h0, 4'h6, 4'h7,
                    64'h8877_6655_4433_2211, 64'h64A, SAOK, 1'b1, 1'b1};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h10, 1, -1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0,
                    SAOK, 1'b1, 1'b1};
        vecs[8] = '{64'h680, 80'h30, 1, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, SADR, 1'b1, 1'b0};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_ifun", 64'(ifun), 64'd0);
        chk("rst_rA", 64'(rA), 64'hF);
        chk("rst_rB", 64'(rB), 64'hF);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_stat", 64'(stat), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // irmovq -> OPq -> halt chain with zero-wait memory.
        load(64'h100, 80'h0A_F4_30, 10);
        load(64'h10A, 80'h23_60, 2);
        mem[12'h10C] = 8'h00;
        exp_q.push_back(mk(4'h3, 4'h0, 4'hF, 4'h4, 64'd10, 64'h10A, SAOK, 1'b1));
        exp_q.push_back(mk(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'h10C, SAOK, 1'b1));
        exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h10D, SHLT, 1'b1));
        kick(64'h100);
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", imem_addr, 64'h100);
        wait_valid(n);
        chk("latency_irmovq", 64'(n + 1), 64'd11);
        wait_done(xf);
        chk("halted_req", 64'(imem_req), 64'd0);
        chk("halted_busy", 64'(busy), 64'd0);

        // jXX accepted with a redirect.
        load(64'h300, 80'h02_00_70, 9);
        mem[12'h309] = 8'h10;
        mem[12'h200] = 8'h00;
        exp_q.push_back(mk(4'h7, 4'h0, 4'hF, 4'hF, 64'h200, 64'h309, SAOK, 1'b1));
        exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h201, SHLT, 1'b1));
        out_ready = 1'b0;
        kick(64'h300);
        wait_valid(n);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        out_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redirect_req", 64'(imem_req), 64'd1);
        chk("redirect_addr", imem_addr, 64'h200);
        chk("redirect_out_valid_drop", 64'(out_valid), 64'd0);
        wait_done(xf);

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            load(vecs[i].pc, vecs[i].bytes, vecs[i].nb);
            if (vecs[i].chain) mem[vecs[i].valp[11:0]] = 8'h00;
            err_en   = (vecs[i].err_off >= 0);
            err_addr = vecs[i].pc + 64'(vecs[i].err_off);
            exp_q.push_back(mk(vecs[i].icode, vecs[i].ifun, vecs[i].ra, vecs[i].rb, vecs[i].valc,
                               vecs[i].valp, vecs[i].stat, vecs[i].chk_valp));
            if (vecs[i].chain)
                exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, vecs[i].valp + 64'd1, SHLT, 1'b1));
            kick(vecs[i].pc);
            wait_done(xf);
            chk("transfers", 64'(xf), 64'(vecs[i].nb + (vecs[i].chain ? 1 : 0)));
            chk("end_req", 64'(imem_req), 64'd0);
            err_en = 1'b0;
        end

        // Random memory gaps, then output back-pressure with a stray redirect.
        load(64'h700, 80'h11_22_33_44_55_66_77_88_F7_30, 10);
        mem[12'h70A] = 8'h00;
        exp_q.push_back(mk(4'h3, 4'h0, 4'hF, 4'h7, 64'h1122_3344_5566_7788, 64'h70A, SAOK, 1'b1));
        exp_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h70B, SHLT, 1'b1));
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hBAD;
        kick(64'h700);
        n = 0;
        prev_pend = 1'b0;
        prev_addr = 64'd0;
        while (!out_valid && n < 300) begin
            if (prev_pend) begin
                chk("req_held", 64'(imem_req), 64'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            rvalid_en = 1'($urandom_range(0, 1));
            prev_pend = imem_req && !rvalid_en;
            prev_addr = imem_addr;
            @(negedge clk);
            n++;
        end
        rvalid_en = 1'b1;
        chk("gap_fetch_in_budget", 64'(n < 300), 64'd1);
        e = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_req", 64'(imem_req), 64'd0);
            chk("stall_rB", 64'(rB), 64'(e.rb));
            chk("stall_valC", valC, e.valc);
            chk("stall_valP", valP, e.valp);
            chk("stall_stat", 64'(stat), 64'(e.stat));
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        wait_done(xf);

        // Reset in the middle of a fetch.
        kick(64'h100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req", 64'(imem_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_valC", valC, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_req", 64'(imem_req), 64'd0);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
